// File: rtl/edulent_memory.sv
// rtl/edulent_memory.sv - CPU-facing RAM with host byte loader and bulk-clear engine
module edulent_memory #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_data_write,
    input  logic              i_mem_write_enable,
    output logic [DATA_W-1:0] o_mem_data_read,
    input  logic              i_load_start,
    input  logic [ADDR_W:0]   i_load_len,
    input  logic              i_load_valid,
    input  logic [DATA_W-1:0] i_load_data,
    output logic              o_load_ready,
    input  logic              i_clear_start,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_load_error,
    output logic [DATA_W-1:0] o_checksum
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   len_q;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] sum_q;
    logic              err_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              len_ok;
    logic              load_go;
    logic              load_bad;
    logic              clear_go;
    logic              load_acc;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign len_ok   = (i_load_len != '0) && (i_load_len <= (ADDR_W+1)'(DEPTH));
    assign load_go  = (state_q == S_IDLE) && i_load_start && len_ok;
    assign load_bad = (state_q == S_IDLE) && i_load_start && !len_ok;
    // A load strobe (legal or not) always takes priority over a clear strobe.
    assign clear_go = (state_q == S_IDLE) && !i_load_start && i_clear_start;
    assign load_acc = (state_q == S_LOAD) && i_load_valid;

    always_comb begin
        state_d   = state_q;
        mem_we    = 1'b0;
        mem_waddr = i_mem_addr;
        mem_wdata = i_mem_data_write;
        case (state_q)
            S_IDLE: begin
                mem_we = i_mem_write_enable;
                if (load_go) begin
                    state_d = S_LOAD;
                end else if (clear_go) begin
                    state_d = S_CLEAR;
                end
            end
            S_LOAD: begin
                mem_we    = i_load_valid;
                mem_waddr = cnt_q[ADDR_W-1:0];
                mem_wdata = i_load_data;
                if (load_acc && (cnt_q + (ADDR_W+1)'(1) == len_q)) begin
                    state_d = S_DONE;
                end
            end
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q[ADDR_W-1:0];
                mem_wdata = '0;
                if (cnt_q[ADDR_W-1:0] == '1) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (i_rst) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            rd_q    <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= load_bad;
            // Write-first: a same-cycle CPU write is what the CPU reads back.
            if (state_q == S_IDLE) begin
                rd_q <= i_mem_write_enable ? i_mem_data_write : mem[i_mem_addr];
            end else begin
                rd_q <= '0;
            end
            if (load_go) begin
                len_q <= i_load_len;
                cnt_q <= '0;
                sum_q <= '0;
            end else if (clear_go) begin
                cnt_q <= '0;
            end else if (load_acc || (state_q == S_CLEAR)) begin
                cnt_q <= cnt_q + (ADDR_W+1)'(1);
            end
            if (load_acc) begin
                sum_q <= sum_q + i_load_data;
            end
        end
    end

    // RAM array has no reset so partial loads/clears survive a reset.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign o_cpu_hold      = (state_q != S_IDLE);
    assign o_load_ready    = (state_q == S_LOAD);
    assign o_done          = (state_q == S_DONE);
    assign o_load_error    = err_q;
    assign o_checksum      = sum_q;
    assign o_mem_data_read = o_cpu_hold ? '0 : rd_q;

endmodule
